id_hazard_unit: RTL and testbench

Decode-stage hazard and bypass controller for the 5-stage CPU pipeline (IF, ID, EX, DM, WB). It tracks the destination register of every in-flight instruction through ID_EX, EX_DM and DM_WB. From that it produces the registered bypass selects the EX-stage source muxes consume, and detects load-use and ext-use hazards that require a one-cycle ID stall with bubble insertion. It sits between instruction decode and the ID_EX pipeline register and drives the EX source-mux selects directly.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/id_hazard_unit_if.sv | 43 ++++
 rtl/hzd_match.sv | 32 +++
 rtl/id_hazard_unit.sv | 108 ++++++++++
 tb/tb_id_hazard_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard/bypass controller: tracker entry, bubble, RF address width.
// Latency: n/a (types only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int RF_AW = 5;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] dst;
        logic             ld;
        logic             ext;
    } trk_t;

    localparam trk_t TRK_BUBBLE = '{we: 1'b0, dst: '0, ld: 1'b0, ext: 1'b0};

    // r0 is hardwired zero, so it never produces a dependency.
    function automatic logic src_hit(input logic re, input logic [RF_AW-1:0] addr, input trk_t e);
        return re && (addr != '0) && e.we && (e.dst == addr);
    endfunction

endpackage

// File: rtl/id_hazard_unit_if.sv
// Decode-side bundle between ID, the hazard unit and the EX source muxes.
// Latency: n/a (wiring only).
// Backpressure: none; stall outputs are the pipeline's hold signals.
interface id_hazard_unit_if;
    import hazard_pkg::*;

    logic             freeze;
    logic             flush;
    logic             re0_ID;
    logic             re1_ID;
    logic [RF_AW-1:0] src0_addr_ID;
    logic [RF_AW-1:0] src1_addr_ID;
    logic             we_ID;
    logic [RF_AW-1:0] dst_addr_ID;
    logic             ld_ID;
    logic             ext_ID;
    logic             byp0_EX;
    logic             byp1_EX;
    logic             byp0_ext_EX;
    logic             byp1_ext_EX;
    logic             byp0_DM;
    logic             byp1_DM;
    logic             stall_IF_ID;
    logic             stall_ID_EX;
    logic             we_ID_EX;
    logic             we_EX_DM;
    logic             we_DM_WB;

    modport master (
        output freeze, flush, re0_ID, re1_ID, src0_addr_ID, src1_addr_ID,
               we_ID, dst_addr_ID, ld_ID, ext_ID,
        input  byp0_EX, byp1_EX, byp0_ext_EX, byp1_ext_EX, byp0_DM, byp1_DM,
               stall_IF_ID, stall_ID_EX, we_ID_EX, we_EX_DM, we_DM_WB
    );

    modport slave (
        input  freeze, flush, re0_ID, re1_ID, src0_addr_ID, src1_addr_ID,
               we_ID, dst_addr_ID, ld_ID, ext_ID,
        output byp0_EX, byp1_EX, byp0_ext_EX, byp1_ext_EX, byp0_DM, byp1_DM,
               stall_IF_ID, stall_ID_EX, we_ID_EX, we_EX_DM, we_DM_WB
    );

endinterface

// File: rtl/hzd_match.sv
// One source operand checked against the ID_EX and EX_DM tracker entries.
// Latency: combinational.
// Backpressure: none; hazard output feeds the stall logic.
module hzd_match
    import hazard_pkg::*;
(
    input  logic             re,
    input  logic [RF_AW-1:0] addr,
    input  trk_t             id_ex,
    input  trk_t             ex_dm,
    output logic             byp_ex,
    output logic             byp_ext_ex,
    output logic             byp_dm,
    output logic             hazard
);

    logic hit_ex;
    logic hit_dm;
    logic unused_ex_dm;

    assign hit_ex = src_hit(re, addr, id_ex);
    assign hit_dm = src_hit(re, addr, ex_dm);

    // The youngest producer shadows an older one writing the same register.
    assign hazard     = hit_ex & id_ex.ld;
    assign byp_ext_ex = hit_ex & ~id_ex.ld &  id_ex.ext;
    assign byp_ex     = hit_ex & ~id_ex.ld & ~id_ex.ext;
    assign byp_dm     = ~hit_ex & hit_dm;

    assign unused_ex_dm = ^{ex_dm.ld, ex_dm.ext};

endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage hazard detect + registered EX bypass selects; ext bypass enabled by ID_HAZARD_EXT_BYP_EN.
// Latency: byp*/we_* registered (1 cycle), stall_* combinational.
// Backpressure: stall_* hold IF/ID for one cycle on load/ext-use; freeze holds everything.
module id_hazard_unit
    import hazard_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    id_hazard_unit_if.slave hz
);

    trk_t       id_ex_q;
    trk_t       ex_dm_q;
    trk_t       dm_wb_q;
    trk_t       id_entry;
    logic [1:0] m_byp_ex;
    logic [1:0] m_byp_ext;
    logic [1:0] m_byp_dm;
    logic [1:0] m_hazard;
    logic       hazard;
    logic [1:0] byp_ex_q;
    logic [1:0] byp_dm_q;
    logic       unused_bits;

    hzd_match u_match0 (
        .re         (hz.re0_ID),
        .addr       (hz.src0_addr_ID),
        .id_ex      (id_ex_q),
        .ex_dm      (ex_dm_q),
        .byp_ex     (m_byp_ex[0]),
        .byp_ext_ex (m_byp_ext[0]),
        .byp_dm     (m_byp_dm[0]),
        .hazard     (m_hazard[0])
    );

    hzd_match u_match1 (
        .re         (hz.re1_ID),
        .addr       (hz.src1_addr_ID),
        .id_ex      (id_ex_q),
        .ex_dm      (ex_dm_q),
        .byp_ex     (m_byp_ex[1]),
        .byp_ext_ex (m_byp_ext[1]),
        .byp_dm     (m_byp_dm[1]),
        .hazard     (m_hazard[1])
    );

    assign hazard = |m_hazard;

`ifdef ID_HAZARD_EXT_BYP_EN
    logic [1:0] byp_ext_q;

    assign id_entry = '{we: hz.we_ID, dst: hz.dst_addr_ID, ld: hz.ld_ID, ext: hz.ext_ID};
    assign unused_bits = ^{dm_wb_q.dst, dm_wb_q.ld, dm_wb_q.ext};

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_ext_q <= '0;
        end else if (!hz.freeze) begin
            byp_ext_q <= (hz.flush || hazard) ? 2'b00 : m_byp_ext;
        end
    end

    assign hz.byp0_ext_EX = byp_ext_q[0];
    assign hz.byp1_ext_EX = byp_ext_q[1];
`else
    // Without the ext bypass, an ext producer resolves like a load: stall once, then DM bypass.
    assign id_entry = '{we: hz.we_ID, dst: hz.dst_addr_ID, ld: hz.ld_ID | hz.ext_ID, ext: 1'b0};
    assign unused_bits = ^{dm_wb_q.dst, dm_wb_q.ld, dm_wb_q.ext, m_byp_ext};

    assign hz.byp0_ext_EX = 1'b0;
    assign hz.byp1_ext_EX = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= TRK_BUBBLE;
            ex_dm_q  <= TRK_BUBBLE;
            dm_wb_q  <= TRK_BUBBLE;
            byp_ex_q <= '0;
            byp_dm_q <= '0;
        end else if (!hz.freeze) begin
            dm_wb_q <= ex_dm_q;
            ex_dm_q <= id_ex_q;
            if (hz.flush || hazard) begin
                id_ex_q  <= TRK_BUBBLE;
                byp_ex_q <= '0;
                byp_dm_q <= '0;
            end else begin
                id_ex_q  <= id_entry;
                byp_ex_q <= m_byp_ex;
                byp_dm_q <= m_byp_dm;
            end
        end
    end

    // A squashed instruction's hazard is irrelevant; freeze already holds the pipe.
    assign hz.stall_IF_ID = hazard & ~hz.flush & ~hz.freeze & ~rst;
    assign hz.stall_ID_EX = hazard & ~hz.flush & ~hz.freeze & ~rst;

    assign hz.byp0_EX  = byp_ex_q[0];
    assign hz.byp1_EX  = byp_ex_q[1];
    assign hz.byp0_DM  = byp_dm_q[0];
    assign hz.byp1_DM  = byp_dm_q[1];
    assign hz.we_ID_EX = id_ex_q.we;
    assign hz.we_EX_DM = ex_dm_q.we;
    assign hz.we_DM_WB = dm_wb_q.we;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Randomized + directed bench for id_hazard_unit with an in-bench pipeline model and scoreboard.
module tb_id_hazard_unit;
    import hazard_pkg::*;

`ifdef ID_HAZARD_EXT_BYP_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_hazard_unit_if hz();

    id_hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        bit we;
        int dst;
        bit ld;
        bit ext;
    } instr_t;

    typedef struct {
        int       cyc;
        string    name;
        bit [5:0] exp;
    } chk_t;

    instr_t   pipe [3];
    bit [5:0] byp_m;
    chk_t     sbq [$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    bit       last_stall;

    always @(posedge clk) cyc++;

    // byp vector order: {b0_EX, b1_EX, b0_ext, b1_ext, b0_DM, b1_DM}
    function automatic bit [5:0] act_vec(string n);
        if (n == "stall") return {4'b0, hz.stall_IF_ID, hz.stall_ID_EX};
        if (n == "byp")   return {hz.byp0_EX, hz.byp1_EX, hz.byp0_ext_EX, hz.byp1_ext_EX, hz.byp0_DM, hz.byp1_DM};
        return {3'b0, hz.we_ID_EX, hz.we_EX_DM, hz.we_DM_WB};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                chk_t c;
                bit [5:0] a;
                c = sbq.pop_front();
                a = act_vec(c.name);
                checks++;
                if (a !== c.exp || c.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b expected=%b", c.name, cyc, a, c.exp);
                end
            end
        end
    end

    // Source dependency resolved from the instructions currently in EX (pipe[0]) and DM (pipe[1]).
    function automatic void src_chk(input bit re, input int a,
                                    output bit hzd, output bit bex, output bit bext, output bit bdm);
        hzd = 0; bex = 0; bext = 0; bdm = 0;
        if (!re || a == 0) return;
        if (pipe[0].we && pipe[0].dst == a) begin
            if (pipe[0].ld || (pipe[0].ext && !EXT_EN)) hzd = 1;
            else if (pipe[0].ext) bext = 1;
            else bex = 1;
        end else if (pipe[1].we && pipe[1].dst == a) begin
            bdm = 1;
        end
    endfunction

    task automatic step(input bit r0, input int s0, input bit r1, input int s1,
                        input bit w, input int d, input bit l, input bit e,
                        input bit fl, input bit fz, input bit rs);
        bit h0, x0, t0, m0, h1, x1, t1, m1, hzd, stl;
        instr_t ni;
        @(posedge clk);
        #1;
        rst = rs;
        hz.freeze = fz;  hz.flush = fl;
        hz.re0_ID = r0;  hz.src0_addr_ID = RF_AW'(s0);
        hz.re1_ID = r1;  hz.src1_addr_ID = RF_AW'(s1);
        hz.we_ID = w;    hz.dst_addr_ID = RF_AW'(d);
        hz.ld_ID = l;    hz.ext_ID = e;
        src_chk(r0, s0, h0, x0, t0, m0);
        src_chk(r1, s1, h1, x1, t1, m1);
        hzd = h0 | h1;
        stl = !rs && !fz && !fl && hzd;
        last_stall = stl;
        sbq.push_back('{cyc, "stall", {4'b0, stl, stl}});
        if (rs) begin
            foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
            byp_m = '0;
        end else if (!fz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (fl || hzd) begin
                pipe[0] = '{0, 0, 0, 0};
                byp_m = '0;
            end else begin
                ni.we = w; ni.dst = d; ni.ld = l; ni.ext = e;
                pipe[0] = ni;
                byp_m = {x0, x1, t0, t1, m0, m1};
            end
        end
        sbq.push_back('{cyc + 1, "byp", byp_m});
        sbq.push_back('{cyc + 1, "we", {3'b0, pipe[0].we, pipe[1].we, pipe[2].we}});
    endtask

    // Front end holds the ID instruction while the unit stalls.
    task automatic issue(input bit r0, input int s0, input bit r1, input int s1,
                         input bit w, input int d, input bit l, input bit e);
        step(r0, s0, r1, s1, w, d, l, e, 0, 0, 0);
        for (int n = 0; n < 3 && last_stall; n++)
            step(r0, s0, r1, s1, w, d, l, e, 0, 0, 0);
    endtask

    initial begin
        bit r0, r1, w, l, e, fl, fz, rs, hold;
        int s0, s1, d;
        rst = 1'b1;
        hz.freeze = 0; hz.flush = 0; hz.re0_ID = 0; hz.re1_ID = 0;
        hz.src0_addr_ID = '0; hz.src1_addr_ID = '0; hz.we_ID = 0;
        hz.dst_addr_ID = '0; hz.ld_ID = 0; hz.ext_ID = 0;
        foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
        byp_m = '0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // ALU producer r3 -> consumer src0
        issue(0, 0, 0, 0, 1, 3, 0, 0);
        issue(1, 3, 0, 0, 1, 10, 0, 0);
        // load r5 -> consumer src1 (stall, then DM bypass)
        issue(0, 0, 0, 0, 1, 5, 1, 0);
        issue(0, 0, 1, 5, 1, 11, 0, 0);
        // two writers of r7, youngest wins on both sources
        issue(0, 0, 0, 0, 1, 7, 0, 0);
        issue(0, 0, 0, 0, 1, 7, 0, 0);
        issue(1, 7, 1, 7, 0, 0, 0, 0);
        // r0 never bypassed
        issue(0, 0, 0, 0, 1, 0, 0, 0);
        issue(1, 0, 1, 0, 1, 12, 0, 0);
        // ext producer r9
        issue(0, 0, 0, 0, 1, 9, 0, 1);
        issue(1, 9, 0, 0, 1, 13, 0, 0);
        // load-use squashed by flush
        issue(0, 0, 0, 0, 1, 5, 1, 0);
        step(1, 5, 0, 0, 1, 14, 0, 0, 1, 0, 0);
        // freeze across a pending load-use
        issue(0, 0, 0, 0, 1, 6, 1, 0);
        repeat (3) step(1, 6, 0, 0, 1, 15, 0, 0, 0, 1, 0);
        issue(1, 6, 0, 0, 1, 15, 0, 0);
        // reset mid-stall
        issue(0, 0, 0, 0, 1, 4, 1, 0);
        step(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1);
        issue(0, 0, 1, 4, 0, 0, 0, 0);

        hold = 0;
        r0 = 0; r1 = 0; s0 = 0; s1 = 0; w = 0; d = 0; l = 0; e = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!hold) begin
                r0 = ($urandom_range(0, 3) != 0);
                r1 = ($urandom_range(0, 3) != 0);
                s0 = $urandom_range(0, 7);
                s1 = $urandom_range(0, 7);
                w  = ($urandom_range(0, 4) != 0);
                d  = $urandom_range(0, 7);
                l  = ($urandom_range(0, 3) == 0);
                e  = !l && ($urandom_range(0, 4) == 0);
            end
            fl = ($urandom_range(0, 11) == 0);
            fz = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 99) == 0);
            step(r0, s0, r1, s1, w, d, l, e, fl, fz, rs);
            hold = !rs && (last_stall || fz);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
